operand_fetch: RTL

- Issue stage between instruction decode and execute in the 32-bit CPU pipeline.
- Accepts one decoded instruction per cycle and drives the register file read addresses (address_A/address_B).
- Collects bus_A/bus_B, with writeback bypass applied, into a registered operand packet for execute.
- Tracks destination registers still in flight in a per-register busy scoreboard and stalls decode on RAW/WAW hazards.
- Passes the writeback port through to the register file write side.

---
 rtl/operand_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage between decode and execute.
//
// Takes one decoded instruction per cycle. It drives the register file read
// addresses and captures the read data into a registered operand packet for
// execute. The writeback value is bypassed into that packet, because the
// register file commits it on the same edge.
//
// A per-register busy scoreboard tracks destinations that are still in flight.
// Decode is stalled on RAW and WAW hazards against those registers. The
// writeback port is also passed straight through to the register file write
// side.
//
// Ports:
//   clk, reset             pipeline clock, synchronous active-high reset
//   in_*                   decoded instruction handshake and fields
//   rf_address_A/B         register file read addresses (combinational)
//   rf_bus_A/B             register file read data
//   wb_valid/addr/data     writeback from the end of the pipeline
//   rf_register_load,
//   rf_address_D, rf_bus_D register file write side (= writeback)
//   out_*                  registered operand packet with valid/ready handshake

module operand_fetch #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int CTRL_W   = 8,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_rd_we,
  input  logic [CTRL_W-1:0] in_ctrl,
  // register file read side
  output logic [AW-1:0]     rf_address_A,
  output logic [AW-1:0]     rf_address_B,
  input  logic [WIDTH-1:0]  rf_bus_A,
  input  logic [WIDTH-1:0]  rf_bus_B,
  // writeback and register file write side
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              rf_register_load,
  output logic [AW-1:0]     rf_address_D,
  output logic [WIDTH-1:0]  rf_bus_D,
  // execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_op_a,
  output logic [WIDTH-1:0]  out_op_b,
  output logic [AW-1:0]     out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_op_a_q;
  logic [WIDTH-1:0]  out_op_b_q;
  logic [AW-1:0]     out_rd_q;
  logic              out_rd_we_q;
  logic [CTRL_W-1:0] out_ctrl_q;

  logic [WIDTH-1:0]  op_a_d;
  logic [WIDTH-1:0]  op_b_d;
  logic              raw;
  logic              waw;
  logic              in_fire;

  // Register file read addresses and write-side pass-through
  assign rf_address_A     = in_rs1;
  assign rf_address_B     = in_rs2;
  assign rf_register_load = wb_valid;
  assign rf_address_D     = wb_addr;
  assign rf_bus_D         = wb_data;

  // The register file is written on the same edge that captures the
  // operands, so its read data is stale for the register being written back.
  assign op_a_d = (wb_valid && wb_addr == in_rs1) ? wb_data : rf_bus_A;
  assign op_b_d = (wb_valid && wb_addr == in_rs2) ? wb_data : rf_bus_B;

  // Per-register clear (writeback) and set (newly issued writer)
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign clr[gi]    = wb_valid && (wb_addr == AW'(gi));
    assign set[gi]    = in_fire && in_rd_we && (in_rd == AW'(gi));
    // Set wins over clear: the new writer is younger than the one retiring.
    assign busy_d[gi] = set[gi] | (busy_q[gi] & ~clr[gi]);
  end

  // A register that retires this cycle no longer blocks; its value is
  // picked up through the bypass.
  assign raw = (busy_q[in_rs1] && !clr[in_rs1]) ||
               (busy_q[in_rs2] && !clr[in_rs2]);
  assign waw = in_rd_we && busy_q[in_rd] && !clr[in_rd];

  assign in_ready = !reset && !raw && !waw && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_op_a_q  <= op_a_d;
        out_op_b_q  <= op_b_d;
        out_rd_q    <= in_rd;
        out_rd_we_q <= in_rd_we;
        out_ctrl_q  <= in_ctrl;
      end else if (out_valid_q && out_ready) begin
        // Drained with nothing behind it; data keeps its last value.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = out_op_a_q;
  assign out_op_b  = out_op_b_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign out_ctrl  = out_ctrl_q;

  // The WAW stall keeps each register down to a single outstanding writer.
  a_single_writer: assert property (@(posedge clk) disable iff (reset)
    !(in_fire && in_rd_we && busy_q[in_rd] && !clr[in_rd]));

endmodule
